// File: rtl/snn_stream_loader.sv
// Host-side byte-serial loader for the SNN core: streams weights and inputs MSB-first,
// runs execute for a programmed cycle count and accumulates lagged per-output spike counts.
module snn_stream_loader #(
   parameter int INPUTS  = 16,
   parameter int WEIGHTS = 384,
   parameter int OUTPUTS = 8,
   parameter int EXEC_W  = 10,
   parameter int COUNT_W = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic                       i_load_weights,
   input  logic [WEIGHTS-1:0]         i_weights_vec,
   input  logic [INPUTS-1:0]          i_inputs_vec,
   input  logic [EXEC_W-1:0]          i_exec_cycles,
   output logic [7:0]                 o_data_out,
   output logic                       o_input_weights,
   output logic                       o_execute,
   input  logic [OUTPUTS-1:0]         i_spikes_in,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [OUTPUTS*COUNT_W-1:0] o_spike_count
);

   localparam int NW    = WEIGHTS / 8;
   localparam int NI    = INPUTS / 8;
   localparam int NMAX  = (NW > NI) ? NW : NI;
   localparam int IDX_W = $clog2(NMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_I, S_EXEC, S_DRAIN, S_DONE
   } state_t;

   state_t                            r_state, w_state_nxt;
   logic [WEIGHTS-1:0]                r_wsh, w_wsh_nxt;
   logic [INPUTS-1:0]                 r_ish, w_ish_nxt;
   logic [IDX_W-1:0]                  r_idx, w_idx_nxt;
   logic [EXEC_W-1:0]                 r_ecnt, w_ecnt_nxt;
   logic [7:0]                        r_data, w_data_nxt;
   logic                              r_iw, w_iw_nxt;
   logic                              r_exec, w_exec_nxt;
   logic                              r_exec_d;
   logic                              r_busy, w_busy_nxt;
   logic                              r_done, w_done_nxt;
   logic                              w_clr;
   logic [OUTPUTS-1:0][COUNT_W-1:0]   r_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_wsh_nxt   = r_wsh;
      w_ish_nxt   = r_ish;
      w_idx_nxt   = r_idx;
      w_ecnt_nxt  = r_ecnt;
      w_data_nxt  = 8'h00;
      w_iw_nxt    = 1'b0;
      w_exec_nxt  = 1'b0;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         S_IDLE: begin
            // The cycle showing done still belongs to the previous run, so start is ignored there.
            if (i_start && !r_done) begin
               w_clr      = 1'b1;
               w_busy_nxt = 1'b1;
               w_ecnt_nxt = i_exec_cycles;
               w_idx_nxt  = IDX_W'(1);
               if (i_load_weights) begin
                  w_state_nxt = S_LOAD_W;
                  w_data_nxt  = i_weights_vec[WEIGHTS-1 -: 8];
                  w_iw_nxt    = 1'b1;
                  w_wsh_nxt   = i_weights_vec << 8;
                  w_ish_nxt   = i_inputs_vec;
               end else begin
                  w_state_nxt = S_LOAD_I;
                  w_data_nxt  = i_inputs_vec[INPUTS-1 -: 8];
                  w_ish_nxt   = i_inputs_vec << 8;
               end
            end
         end
         S_LOAD_W: begin
            if (r_idx < IDX_W'(NW)) begin
               w_data_nxt = r_wsh[WEIGHTS-1 -: 8];
               w_iw_nxt   = 1'b1;
               w_wsh_nxt  = r_wsh << 8;
               w_idx_nxt  = r_idx + IDX_W'(1);
            end else begin
               w_state_nxt = S_LOAD_I;
               w_data_nxt  = r_ish[INPUTS-1 -: 8];
               w_ish_nxt   = r_ish << 8;
               w_idx_nxt   = IDX_W'(1);
            end
         end
         S_LOAD_I: begin
            if (r_idx < IDX_W'(NI)) begin
               w_data_nxt = r_ish[INPUTS-1 -: 8];
               w_ish_nxt  = r_ish << 8;
               w_idx_nxt  = r_idx + IDX_W'(1);
            end else if (r_ecnt != '0) begin
               w_state_nxt = S_EXEC;
               w_exec_nxt  = 1'b1;
               w_ecnt_nxt  = r_ecnt - EXEC_W'(1);
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_EXEC: begin
            if (r_ecnt != '0) begin
               w_exec_nxt = 1'b1;
               w_ecnt_nxt = r_ecnt - EXEC_W'(1);
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN, S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_wsh    <= '0;
         r_ish    <= '0;
         r_idx    <= '0;
         r_ecnt   <= '0;
         r_data   <= 8'h00;
         r_iw     <= 1'b0;
         r_exec   <= 1'b0;
         r_exec_d <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_wsh    <= w_wsh_nxt;
         r_ish    <= w_ish_nxt;
         r_idx    <= w_idx_nxt;
         r_ecnt   <= w_ecnt_nxt;
         r_data   <= w_data_nxt;
         r_iw     <= w_iw_nxt;
         r_exec   <= w_exec_nxt;
         r_exec_d <= r_exec;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // The core's spike outputs reflect the previous execute cycle, hence the delayed enable.
   always_ff @(posedge i_clk) begin
      if (i_reset || w_clr) begin
         r_cnt <= '0;
      end else if (r_exec_d) begin
         for (int k = 0; k < OUTPUTS; k++) begin
            if (i_spikes_in[k] && (r_cnt[k] != {COUNT_W{1'b1}}))
               r_cnt[k] <= r_cnt[k] + COUNT_W'(1);
         end
      end
   end

   assign o_data_out      = r_data;
   assign o_input_weights = r_iw;
   assign o_execute       = r_exec;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_spike_count   = r_cnt;

endmodule

// File: doc/snn_stream_loader.md
Name: snn_stream_loader

Overview:
- Host-side transmitter for the SNN core's byte-serial load/execute interface.
- Each run:
  - optionally serialises a weight vector byte by byte,
  - serialises an input-spike vector,
  - raises execute for a programmed number of cycles,
  - accumulates per-output spike counts from the core's spike outputs.
- Sits between a test controller or CPU and the core pins: data byte bus, input_weights strobe, execute strobe, spike outputs.

Parameters:
- INPUTS, 16, input vector width; must be a multiple of 8.
- WEIGHTS, 384, weight vector width (16x16 + 16x8); must be a multiple of 8.
- OUTPUTS, 8, number of spike outputs observed.
- EXEC_W, 10, width of the exec_cycles operand.
- COUNT_W, 8, width of each spike counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- load_weights  in  1  sampled with start; 1 = send weights before inputs.
- weights_vec  in  WEIGHTS  weight image, sampled with start.
- inputs_vec  in  INPUTS  input image, sampled with start.
- exec_cycles  in  EXEC_W  number of execute cycles, sampled with start.
- data_out  out  8  byte to core data bus.
- input_weights  out  1  1 = byte is a weight byte, 0 = input byte.
- execute  out  1  1 = core runs; 0 = core shifts data_out in.
- spikes_in  in  OUTPUTS  core spike outputs.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of run.
- spike_count  out  OUTPUTS*COUNT_W  per-output counts; counter k at [k*COUNT_W +: COUNT_W].

Behaviour:
- All outputs registered.
- Reset values: data_out=0, input_weights=0, execute=0, busy=0, done=0, all counts 0, state IDLE.
- IDLE drives data_out=0, input_weights=0, execute=0.
  - Inputs are deliberately flushed to zero while idle; weights are untouched.
- Byte order is MSB-first, because the core shifts each new byte into its LSB end:
  - weight byte k (k=0..W-1, W=WEIGHTS/8) = weights_vec[WEIGHTS-1-8k -: 8];
  - input byte j (j=0..I-1, I=INPUTS/8) = inputs_vec[INPUTS-1-8j -: 8].
- FSM states: IDLE, LOAD_W, LOAD_I, EXEC, DRAIN, DONE.
- Timing, with edge 0 being the edge that samples start:
  - start in IDLE: latch operands; clear all counters; busy=1; go to LOAD_W if load_weights, else LOAD_I.
  - LOAD_W: input_weights=1, execute=0. Weight bytes are sampled by the core at edges 1..W.
  - LOAD_I: input_weights=0, execute=0. Input bytes are sampled at edges W'+1..W'+I, where W'=W if load_weights, else 0.
  - EXEC: execute=1, data_out=0, input_weights=0, for exactly exec_cycles cycles. Core samples at edges W'+I+1..W'+I+E.
  - Spike sampling: spikes_in is sampled at edges W'+I+2..W'+I+E+1 (one-cycle lag, via a delayed copy of execute). Each counter increments when its bit is 1.
  - DRAIN covers the final lagged sample.
  - After edge W'+I+E+1: done=1 for exactly one cycle, busy=0, state IDLE.
- exec_cycles=0: EXEC and DRAIN are skipped. done is asserted after edge W'+I+1 and all counts stay 0.
- Counters saturate at 2^COUNT_W-1, with no wrap.
- Counts hold after done until the next accepted start or reset.
- start while busy (including the DONE cycle): ignored. Latched operands are unaffected.
- Operand inputs may change freely after the start cycle.
- reset mid-run: abandons the run immediately and returns all outputs to reset values. No done pulse.

Test Plan:
- Full run, defaults:
  - Stimulus: load_weights=1; weights_vec bytes 0xA5,0x5A alternating from the MSB end; inputs_vec=16'hF00F; exec_cycles=10.
  - Required: data_out shows 48 weight bytes with input_weights=1, then 0xF0,0x0F with input_weights=0.
  - Required: execute is high for exactly 10 cycles; done pulses after edge 61; busy is high edges 1..61.
- Inputs only:
  - Stimulus: load_weights=0, exec_cycles=3, spikes_in tied to 8'h81.
  - Required: 2 input bytes, then 3 execute cycles; done after edge 6.
  - Required: counts = 3 for outputs 0 and 7, and 0 for all others.
- Lag alignment:
  - Stimulus: spikes_in=1 only in the cycle before the first execute edge, plus exactly one cycle after the last execute edge.
  - Required: only the second pulse is counted (count=1).
- Saturation:
  - Stimulus: COUNT_W=4, exec_cycles=20, spikes_in all ones.
  - Required: every count = 15.
- Edge cases:
  - Stimulus: exec_cycles=0.
  - Required: execute never rises, counts are 0, done follows the last input byte.
  - Stimulus: start re-pulsed mid-LOAD_W.
  - Required: ignored, byte sequence unchanged.
- Reset mid-EXEC:
  - Stimulus: assert reset.
  - Required: next cycle execute=0, busy=0, counts=0, no done pulse.
  - Stimulus: new start after reset.
  - Required: a clean full run.
